// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial add/subtract controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_add_ctrl_pkg;

  // Sequencer states: wait for a request, walk the bits, present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Encoding of the sub_i operation-select input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between the control unit (master) and the serial adder (slave).
// Latency: n/a (wiring only).
// Backpressure: none; start_i is ignored by the slave unless it is idle.
// Ports: start_i/sub_i/a_i/b_i request the operation; busy_o/done_o/sum_o/cout_o/ovf_o report it.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;

  modport master (
    output start_i, sub_i, a_i, b_i,
    input  busy_o, done_o, sum_o, cout_o, ovf_o
  );

  modport slave (
    input  start_i, sub_i, a_i, b_i,
    output busy_o, done_o, sum_o, cout_o, ovf_o
  );

endinterface : serial_add_ctrl_if

// File: rtl/serial_add_ctrl_fulladder1bit.sv
// Single-bit full adder cell used as the arithmetic core of the serial adder.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i, c_i operand and carry-in bits; s_o sum bit; c_o carry-out bit.
module fulladder1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule : fulladder1bit

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell walked over WIDTH bits, LSB first.
// Latency: start accepted at edge k -> busy_o for WIDTH cycles -> done_o pulse in cycle k+WIDTH+1.
// Backpressure: none; start_i is only sampled in IDLE, requests in RUN/DONE are dropped.
// Ports: clk_i, rst_ni (async, active low); bus = request/result bundle (slave side).
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  fulladder1bit u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // State register plus datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start_i) state_d = ST_RUN;
      ST_RUN:  if (last_bit)    state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          a_d     = bus.a_i;
          b_d     = (bus.sub_i == OP_SUB) ? ~bus.b_i : bus.b_i;
          carry_d = (bus.sub_i == OP_SUB);
          cnt_d   = '0;
          res_d   = '0;
        end
      end

      ST_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Outputs only change here, so the partial shift contents never leak.
          // carry_q is still the carry into the MSB, which sets signed overflow.
          sum_d  = {fa_sum, res_q[WIDTH-1:1]};
          cout_d = fa_cout;
          ovf_d  = carry_q ^ fa_cout;
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy_o = (state_q == ST_RUN);
    bus.done_o = (state_q == ST_DONE);
    bus.sum_o  = sum_q;
    bus.cout_o = cout_q;
    bus.ovf_o  = ovf_q;
  end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=13.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_drv;
  logic        sub_drv;
  logic        sel_drv;   // 0 = drive the 8-bit instance, 1 = the 13-bit instance
  logic [31:0] a_drv;
  logic [31:0] b_drv;

  int n_checks;
  int n_fail;

  serial_add_ctrl_if #(.WIDTH(8))  if8 ();
  serial_add_ctrl_if #(.WIDTH(13)) if13 ();

  assign if8.start_i  = start_drv & ~sel_drv;
  assign if8.sub_i    = sub_drv;
  assign if8.a_i      = a_drv[7:0];
  assign if8.b_i      = b_drv[7:0];
  assign if13.start_i = start_drv & sel_drv;
  assign if13.sub_i   = sub_drv;
  assign if13.a_i     = a_drv[12:0];
  assign if13.b_i     = b_drv[12:0];

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if8.slave)
  );

  serial_add_ctrl #(.WIDTH(13)) u_dut13 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if13.slave)
  );

  // Outputs of whichever instance is selected
  logic        busy_mon, done_mon, cout_mon, ovf_mon;
  logic [31:0] sum_mon;
  assign busy_mon = sel_drv ? if13.busy_o : if8.busy_o;
  assign done_mon = sel_drv ? if13.done_o : if8.done_o;
  assign cout_mon = sel_drv ? if13.cout_o : if8.cout_o;
  assign ovf_mon  = sel_drv ? if13.ovf_o  : if8.ovf_o;
  assign sum_mon  = sel_drv ? {19'd0, if13.sum_o} : {24'd0, if8.sum_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not reach the end (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input int w, input bit sub, input longint a, input longint b,
                                output longint s, output bit co, output bit ov);
    longint m, sa, sb, r;
    m  = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      s  = (a - b + m) % m;
      co = (a >= b);
      r  = sa - sb;
    end else begin
      s  = (a + b) % m;
      co = ((a + b) >= m);
      r  = sa + sb;
    end
    ov = (r < -(m / 2)) || (r >= (m / 2));
  endfunction

  // Issues one operation from a negedge where the DUT is idle; returns at the negedge of
  // the idle cycle after done. inject>0 pulses a second, different request in that
  // RUN cycle, which must be dropped.
  task automatic run_op(input bit sel, input bit sub, input logic [31:0] a, input logic [31:0] b,
                        input int inject,
                        output logic [31:0] s, output logic co, output logic ov);
    int w;
    int busy_n, done_n, done_at, both;
    w = sel ? 13 : 8;
    busy_n = 0; done_n = 0; done_at = 0; both = 0;
    s = '0; co = 1'b0; ov = 1'b0;
    sel_drv = sel; sub_drv = sub; a_drv = a; b_drv = b; start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
    for (int i = 1; i <= w + 2; i++) begin
      @(negedge clk);
      start_drv = (i == inject);
      if (i == inject) begin
        a_drv = ~a;
        b_drv = a ^ b ^ 32'h5A5A_A5A5;
        sub_drv = ~sub;
      end
      if (busy_mon) busy_n++;
      if (busy_mon && done_mon) both++;
      if (done_mon) begin
        done_n++;
        if (done_at == 0) begin
          done_at = i;
          s  = sum_mon;
          co = cout_mon;
          ov = ovf_mon;
        end
      end
    end
    start_drv = 1'b0;
    check("busy_cycles", 64'(busy_n), 64'(w));
    check("done_latency", 64'(done_at), 64'(w + 1));
    check("done_pulses", 64'(done_n), 64'd1);
    check("busy_done_overlap", 64'(both), 64'd0);
  endtask

  typedef struct {
    bit          sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    bit          co;
    bit          ov;
  } vec_t;

  vec_t dir_vec[5];

  initial begin
    logic [31:0] s_got;
    logic        co_got, ov_got;
    longint      s_exp;
    bit          co_exp, ov_exp;
    logic [31:0] ra, rb, mask;
    bit          rsub;
    int          busy_seen, done_seen;

    n_checks = 0; n_fail = 0;
    start_drv = 1'b0; sub_drv = 1'b0; sel_drv = 1'b0; a_drv = '0; b_drv = '0;

    dir_vec[0] = '{1'b0, 32'h35, 32'h4A, 32'h7F, 1'b0, 1'b0};
    dir_vec[1] = '{1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0};
    dir_vec[2] = '{1'b0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1};
    dir_vec[3] = '{1'b1, 32'h10, 32'h20, 32'hF0, 1'b0, 1'b0};
    dir_vec[4] = '{1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1};

    // Reset values
    rst_n = 1'b0;
    #1;
    check("rst_busy8", 64'(if8.busy_o), 64'd0);
    check("rst_done8", 64'(if8.done_o), 64'd0);
    check("rst_sum8", 64'(if8.sum_o), 64'd0);
    check("rst_cout8", 64'(if8.cout_o), 64'd0);
    check("rst_ovf8", 64'(if8.ovf_o), 64'd0);
    check("rst_busy13", 64'(if13.busy_o), 64'd0);
    check("rst_sum13", 64'(if13.sum_o), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed WIDTH=8 cases, issued back to back
    foreach (dir_vec[k]) begin
      run_op(1'b0, dir_vec[k].sub, dir_vec[k].a, dir_vec[k].b, 0, s_got, co_got, ov_got);
      check($sformatf("dir%0d_sum", k), 64'(s_got), 64'(dir_vec[k].s));
      check($sformatf("dir%0d_cout", k), 64'(co_got), 64'(dir_vec[k].co));
      check($sformatf("dir%0d_ovf", k), 64'(ov_got), 64'(dir_vec[k].ov));
    end

    // Start pulse during RUN cycle 3 must be dropped
    run_op(1'b0, 1'b0, 32'h35, 32'h4A, 3, s_got, co_got, ov_got);
    check("ignored_start_sum", 64'(s_got), 64'h7F);
    check("ignored_start_cout", 64'(co_got), 64'd0);
    check("ignored_start_ovf", 64'(ov_got), 64'd0);
    check("ignored_start_idle_busy", 64'(busy_mon), 64'd0);

    // Load non-zero outputs, then abort an operation with reset in RUN cycle 4
    run_op(1'b0, 1'b1, 32'h80, 32'h01, 0, s_got, co_got, ov_got);
    sel_drv = 1'b0; sub_drv = 1'b0; a_drv = 32'h12; b_drv = 32'h34; start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_mon), 64'd0);
    check("abort_done", 64'(done_mon), 64'd0);
    check("abort_sum", 64'(sum_mon), 64'd0);
    check("abort_cout", 64'(cout_mon), 64'd0);
    check("abort_ovf", 64'(ovf_mon), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy_mon) busy_seen++;
      if (done_mon) done_seen++;
    end
    check("abort_no_busy", 64'(busy_seen), 64'd0);
    check("abort_no_done", 64'(done_seen), 64'd0);
    run_op(1'b0, 1'b0, 32'h12, 32'h34, 0, s_got, co_got, ov_got);
    check("post_abort_sum", 64'(s_got), 64'h46);
    check("post_abort_cout", 64'(co_got), 64'd0);
    check("post_abort_ovf", 64'(ov_got), 64'd0);

    // Randomized operations at both widths, with corner operands mixed in
    for (int sel = 0; sel < 2; sel++) begin
      mask = (sel != 0) ? 32'h1FFF : 32'hFF;
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom & mask;
        rb = $urandom & mask;
        if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? mask : (mask >> 1);
        if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'd0 : ((mask >> 1) + 1);
        rsub = 1'($urandom_range(0, 1));
        model((sel != 0) ? 13 : 8, rsub, longint'(ra), longint'(rb), s_exp, co_exp, ov_exp);
        run_op(1'(sel), rsub, ra, rb, 0, s_got, co_got, ov_got);
        check($sformatf("rnd_w%0d_sum a=%0h b=%0h sub=%0d", (sel != 0) ? 13 : 8, ra, rb, rsub),
              64'(s_got), 64'(s_exp));
        check("rnd_cout", 64'(co_got), 64'(co_exp));
        check("rnd_ovf", 64'(ov_got), 64'(ov_exp));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_add_ctrl
